// File: rtl/video_pattern_gen.sv
// Video timing generator with selectable test patterns (colour bars, grey ramp, grid, solid).
// All outputs are registered one pix_ce after the raster counters and held while pix_ce is low.
module video_pattern_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter int HS_POL    = 1,
    parameter int VS_POL    = 1,
    parameter int COLOR_W   = 4,
    parameter int BAR_LEVEL = 11,
    parameter int GRID      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_ce,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [10:0]            x,
    output logic [9:0]             y,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
    localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [10:0] BAR_LAST    = 11'(H_ACTIVE / 8 - 1);
    localparam logic [10:0] RAMP_LAST   = 11'((H_ACTIVE >> COLOR_W) - 1);
    localparam logic [10:0] GRID_LAST_X = 11'(GRID - 1);
    localparam logic [9:0]  GRID_LAST_Y = 10'(GRID - 1);

    localparam logic [COLOR_W-1:0] BAR_ON   = COLOR_W'(BAR_LEVEL);
    localparam logic [COLOR_W-1:0] STEP_MAX = {COLOR_W{1'b1}};
    localparam logic               HS_ON    = 1'(HS_POL);
    localparam logic               VS_ON    = 1'(VS_POL);

    logic [10:0]            hc_q, hc_d;
    logic [9:0]             vc_q, vc_d;
    logic [10:0]            bar_cnt_q, bar_cnt_d;
    logic [2:0]             bar_idx_q, bar_idx_d;
    logic [10:0]            ramp_cnt_q, ramp_cnt_d;
    logic [COLOR_W-1:0]     step_q, step_d;
    logic [10:0]            gx_q, gx_d;
    logic [9:0]             gy_q, gy_d;
    logic [1:0]             mode_q, mode_d;
    logic [3*COLOR_W-1:0]   solid_q, solid_d;

    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   de_q, de_d;
    logic [10:0]            x_q, x_d;
    logic [9:0]             y_q, y_d;
    logic [COLOR_W-1:0]     red_q, red_d;
    logic [COLOR_W-1:0]     green_q, green_d;
    logic [COLOR_W-1:0]     blue_q, blue_d;
    logic                   fs_q, fs_d;

    logic                   h_wrap;
    logic                   v_wrap;
    logic                   frame_first;
    logic                   active;
    logic                   grid_on;
    logic [1:0]             cur_mode;
    logic [3*COLOR_W-1:0]   cur_solid;
    logic [COLOR_W-1:0]     pix_r, pix_g, pix_b;

    // The pixel at (0,0) already uses the mode being sampled, so a frame is never split across modes.
    always_comb begin
        h_wrap      = (hc_q == H_LAST);
        v_wrap      = (vc_q == V_LAST);
        frame_first = (hc_q == 11'd0) && (vc_q == 10'd0);
        active      = (hc_q < H_ACT) && (vc_q < V_ACT);
        cur_mode    = frame_first ? mode : mode_q;
        cur_solid   = frame_first ? solid_rgb : solid_q;
        grid_on     = (gx_q == 11'd0) || (gy_q == 10'd0) ||
                      (hc_q == H_ACT_LAST) || (vc_q == V_ACT_LAST);

        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (cur_mode)
            2'd0: begin
                pix_r = bar_idx_q[1] ? '0 : BAR_ON;
                pix_g = bar_idx_q[2] ? '0 : BAR_ON;
                pix_b = bar_idx_q[0] ? '0 : BAR_ON;
            end
            2'd1: begin
                pix_r = step_q;
                pix_g = step_q;
                pix_b = step_q;
            end
            2'd2: begin
                pix_r = grid_on ? STEP_MAX : '0;
                pix_g = grid_on ? STEP_MAX : '0;
                pix_b = grid_on ? STEP_MAX : '0;
            end
            default: begin
                pix_r = cur_solid[3*COLOR_W-1 -: COLOR_W];
                pix_g = cur_solid[2*COLOR_W-1 -: COLOR_W];
                pix_b = cur_solid[COLOR_W-1:0];
            end
        endcase
        if (!active) begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
        end
    end

    // Per-line counters replace dividers: each restarts at the line wrap and tracks position within a bar/step/cell.
    always_comb begin
        hc_d       = hc_q;
        vc_d       = vc_q;
        bar_cnt_d  = bar_cnt_q;
        bar_idx_d  = bar_idx_q;
        ramp_cnt_d = ramp_cnt_q;
        step_d     = step_q;
        gx_d       = gx_q;
        gy_d       = gy_q;
        mode_d     = mode_q;
        solid_d    = solid_q;

        if (pix_ce) begin
            hc_d = h_wrap ? 11'd0 : hc_q + 11'd1;
            if (h_wrap) begin
                vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
                gy_d = (v_wrap || gy_q == GRID_LAST_Y) ? 10'd0 : gy_q + 10'd1;
            end

            if (h_wrap) begin
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else if (bar_idx_q != 3'd7) begin
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 11'd1;
                end
            end

            if (h_wrap) begin
                ramp_cnt_d = '0;
                step_d     = '0;
            end else if (ramp_cnt_q == RAMP_LAST) begin
                ramp_cnt_d = '0;
                step_d     = (step_q == STEP_MAX) ? STEP_MAX : step_q + 1'b1;
            end else begin
                ramp_cnt_d = ramp_cnt_q + 11'd1;
            end

            gx_d = (h_wrap || gx_q == GRID_LAST_X) ? 11'd0 : gx_q + 11'd1;

            if (frame_first) begin
                mode_d  = mode;
                solid_d = solid_rgb;
            end
        end
    end

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        x_d     = x_q;
        y_d     = y_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        fs_d    = fs_q;

        if (pix_ce) begin
            hsync_d = (({1'b0, hc_q} >= HS_START) && ({1'b0, hc_q} < HS_END)) ? HS_ON : ~HS_ON;
            vsync_d = (({1'b0, vc_q} >= VS_START) && ({1'b0, vc_q} < VS_END)) ? VS_ON : ~VS_ON;
            de_d    = active;
            x_d     = active ? hc_q : 11'd0;
            y_d     = active ? vc_q : 10'd0;
            red_d   = pix_r;
            green_d = pix_g;
            blue_d  = pix_b;
            fs_d    = active && frame_first;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q       <= '0;
            vc_q       <= '0;
            bar_cnt_q  <= '0;
            bar_idx_q  <= '0;
            ramp_cnt_q <= '0;
            step_q     <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            mode_q     <= '0;
            solid_q    <= '0;
            hsync_q    <= ~HS_ON;
            vsync_q    <= ~VS_ON;
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            fs_q       <= 1'b0;
        end else begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            bar_cnt_q  <= bar_cnt_d;
            bar_idx_q  <= bar_idx_d;
            ramp_cnt_q <= ramp_cnt_d;
            step_q     <= step_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            mode_q     <= mode_d;
            solid_q    <= solid_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            x_q        <= x_d;
            y_q        <= y_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            fs_q       <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a small raster (68x16 active, 92x22 total, negative hsync).
// The driver pushes model pixels per pix_ce; a monitor pops and compares each registered output.
module tb_video_pattern_gen;

    localparam int HA  = 68;
    localparam int HFP = 8;
    localparam int HSY = 8;
    localparam int HBP = 8;
    localparam int VA  = 16;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [10:0] x;
        logic [9:0]  y;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } pix_t;

    localparam pix_t RESET_PIX = '{hs: 1'b1, vs: 1'b0, de: 1'b0, fs: 1'b0,
                                   x: 11'd0, y: 10'd0, r: 4'd0, g: 4'd0, b: 4'd0};

    logic        clk;
    logic        rst;
    logic        pix_ce;
    logic [1:0]  mode;
    logic [11:0] solid_rgb;
    logic        hsync, vsync, de, frame_start;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  red, green, blue;

    pix_t exp_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
    int   hc_m = 0, vc_m = 0;
    logic [1:0]  fmode_m  = 2'd0;
    logic [11:0] fsolid_m = 12'd0;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(0), .VS_POL(1), .COLOR_W(4), .BAR_LEVEL(11), .GRID(8)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .red(red), .green(green), .blue(blue), .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference pixel from raster position, using plain division/modulo arithmetic.
    function automatic pix_t modelPix(int h, int v, logic [1:0] md, logic [11:0] sol);
        pix_t       p;
        int         bar;
        int         stp;
        logic [2:0] on3;
        p = '0;
        p.de = (h < HA) && (v < VA);
        p.hs = (h >= HA + HFP && h < HA + HFP + HSY) ? 1'b0 : 1'b1;
        p.vs = (v >= VA + VFP && v < VA + VFP + VSY) ? 1'b1 : 1'b0;
        if (p.de) begin
            p.x  = 11'(h);
            p.y  = 10'(v);
            p.fs = (h == 0) && (v == 0);
            case (md)
                2'd0: begin
                    bar = h / (HA / 8);
                    if (bar > 7) bar = 7;
                    case (bar)
                        0: on3 = 3'b111;
                        1: on3 = 3'b110;
                        2: on3 = 3'b011;
                        3: on3 = 3'b010;
                        4: on3 = 3'b101;
                        5: on3 = 3'b100;
                        6: on3 = 3'b001;
                        default: on3 = 3'b000;
                    endcase
                    p.r = on3[2] ? 4'd11 : 4'd0;
                    p.g = on3[1] ? 4'd11 : 4'd0;
                    p.b = on3[0] ? 4'd11 : 4'd0;
                end
                2'd1: begin
                    stp = h / (HA >> 4);
                    if (stp > 15) stp = 15;
                    p.r = 4'(stp);
                    p.g = 4'(stp);
                    p.b = 4'(stp);
                end
                2'd2: begin
                    if ((h % 8 == 0) || (v % 8 == 0) || (h == HA - 1) || (v == VA - 1)) begin
                        p.r = 4'hF;
                        p.g = 4'hF;
                        p.b = 4'hF;
                    end
                end
                default: begin
                    p.r = sol[11:8];
                    p.g = sol[7:4];
                    p.b = sol[3:0];
                end
            endcase
        end
        return p;
    endfunction

    task automatic checkOutput(input string name, input pix_t exp);
        pix_t got;
        got = {hsync, vsync, de, frame_start, x, y, red, green, blue};
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s at %0t: got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d rgb=(%0d,%0d,%0d) expected hs=%b vs=%b de=%b fs=%b x=%0d y=%0d rgb=(%0d,%0d,%0d)",
                     name, $time, got.hs, got.vs, got.de, got.fs, got.x, got.y, got.r, got.g, got.b,
                     exp.hs, exp.vs, exp.de, exp.fs, exp.x, exp.y, exp.r, exp.g, exp.b);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        check_cnt++;
        if (got == exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Drives n_pix pixel enables, one every ce_period clocks; mode/solid change at pixel chg_at.
    task automatic applyStimulus(input int n_pix, input int ce_period, input int chg_at,
                                 input logic [1:0] chg_mode, input logic [11:0] chg_solid);
        for (int p = 0; p < n_pix; p++) begin
            if (p == chg_at) begin
                mode      = chg_mode;
                solid_rgb = chg_solid;
            end
            for (int k = 0; k < ce_period; k++) begin
                @(negedge clk);
                pix_ce = (k == ce_period - 1);
                if (pix_ce) begin
                    if (hc_m == 0 && vc_m == 0) begin
                        fmode_m  = mode;
                        fsolid_m = solid_rgb;
                    end
                    exp_q.push_back(modelPix(hc_m, vc_m, fmode_m, fsolid_m));
                    hc_m++;
                    if (hc_m == HT) begin
                        hc_m = 0;
                        vc_m++;
                        if (vc_m == VT) vc_m = 0;
                    end
                end
            end
        end
        @(negedge clk);
        pix_ce = 1'b0;
    endtask

    task automatic checkFrameCounts(input string tag, input int de0, input int hs0, input int vs0, input int fs0);
        checkCount({tag, "_de_pixels"}, de_cnt - de0, HA * VA);
        checkCount({tag, "_hsync_pixels"}, hs_cnt - hs0, HSY * VT);
        checkCount({tag, "_vsync_pixels"}, vs_cnt - vs0, VSY * HT);
        checkCount({tag, "_frame_starts"}, fs_cnt - fs0, 1);
    endtask

    // Monitor: every clock, compare new output on pix_ce edges, held output otherwise, reset values under rst.
    initial begin
        pix_t last;
        logic ce_s, rst_s;
        last = RESET_PIX;
        forever begin
            @(posedge clk);
            ce_s  = pix_ce;
            rst_s = rst;
            #1;
            if (rst_s) begin
                last = RESET_PIX;
                checkOutput("reset_state", last);
            end else if (ce_s) begin
                if (exp_q.size() == 0) begin
                    check_cnt++;
                    $display("[TB] FAIL scoreboard_underflow at %0t: got empty queue expected a pending pixel", $time);
                end else begin
                    last = exp_q.pop_front();
                    checkOutput("pixel", last);
                    if (de) de_cnt++;
                    if (hsync == 1'b0) hs_cnt++;
                    if (vsync == 1'b1) vs_cnt++;
                    if (frame_start) fs_cnt++;
                end
            end else begin
                checkOutput("hold", last);
            end
        end
    end

    initial begin
        int de0, hs0, vs0, fs0;
        rst       = 1'b1;
        pix_ce    = 1'b0;
        mode      = 2'd0;
        solid_rgb = 12'h000;
        repeat (3) @(negedge clk);
        checkOutput("reset_initial", RESET_PIX);
        rst = 1'b0;

        $display("[TB] frame 1: colour bars, pix_ce every clock");
        de0 = de_cnt; hs0 = hs_cnt; vs0 = vs_cnt; fs0 = fs_cnt;
        applyStimulus(FRAME, 1, -1, 2'd0, 12'h000);
        checkFrameCounts("bars", de0, hs0, vs0, fs0);

        $display("[TB] frame 2: ramp, switch to solid mid-frame");
        mode = 2'd1;
        applyStimulus(FRAME, 1, 500, 2'd3, 12'hF0F);

        $display("[TB] frame 3: solid, switch to grid mid-frame");
        applyStimulus(FRAME, 1, 1000, 2'd2, 12'h123);

        $display("[TB] frame 4: grid, pix_ce every 4th clock");
        de0 = de_cnt; hs0 = hs_cnt; vs0 = vs_cnt; fs0 = fs_cnt;
        applyStimulus(FRAME, 4, -1, 2'd2, 12'h123);
        checkFrameCounts("grid_ce4", de0, hs0, vs0, fs0);

        $display("[TB] frame 5: bars, asynchronous reset at hc=30 vc=5");
        mode = 2'd0;
        applyStimulus(5 * HT + 30, 1, -1, 2'd0, 12'h000);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", RESET_PIX);
        hc_m = 0;
        vc_m = 0;
        mode = 2'd3;
        @(negedge clk);
        pix_ce = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pix_ce = 1'b0;
        rst    = 1'b0;
        fs0 = fs_cnt;
        applyStimulus(3 * HT, 1, 0, 2'd0, 12'h000);
        checkCount("restart_frame_start", fs_cnt - fs0, 1);

        @(negedge clk);
        checkCount("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
